// File: rtl/lsu_pkg.sv
// Shared types and helpers for the byte-serialising load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    DT_WORD = 2'b00,
    DT_BYTE = 2'b01,
    DT_HALF = 2'b10,
    DT_RSVD = 2'b11
  } data_type_t;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    RESP
  } lsu_state_t;

  function automatic logic [2:0] bytes_for(input data_type_t t);
    case (t)
      DT_WORD: return 3'd4;
      DT_HALF: return 3'd2;
      default: return 3'd1;
    endcase
  endfunction

  // Natural alignment: halves on even addresses, words on multiples of four.
  function automatic logic misaligned(input data_type_t t, input logic [1:0] a);
    case (t)
      DT_HALF: return a[0];
      DT_WORD: return (a != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_sext.sv
// Combinational size/sign extender turning the byte accumulator into CPU load data.
module lsu_sext
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
) (
  input  data_type_t            i_type,
  input  logic [DATA_WIDTH-1:0] i_acc,
  input  logic                  i_zero,
  output logic [DATA_WIDTH-1:0] o_data
);

  localparam int HALF_WIDTH = 2 * BYTE_WIDTH;

  logic signed [BYTE_WIDTH-1:0] w_byte;
  logic signed [HALF_WIDTH-1:0] w_half;

  assign w_byte = $signed(i_acc[BYTE_WIDTH-1:0]);
  assign w_half = $signed(i_acc[HALF_WIDTH-1:0]);

  always_comb begin
    o_data = '0;
    if (!i_zero) begin
      case (i_type)
        DT_BYTE: o_data = {{(DATA_WIDTH-BYTE_WIDTH){w_byte[BYTE_WIDTH-1]}}, w_byte};
        DT_HALF: o_data = {{(DATA_WIDTH-HALF_WIDTH){w_half[HALF_WIDTH-1]}}, w_half};
        DT_WORD: o_data = i_acc;
        default: o_data = '0;
      endcase
    end
  end

endmodule

// File: rtl/lsu_byte_seq.sv
// Load/store initiator serialising word/half/byte accesses into one byte-wide memory cycle per clock.
// Optional build macro LSU_ALIGN_CHECK_EN rejects misaligned half/word requests with resp_err.
module lsu_byte_seq
  import lsu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 12,
  parameter int DATA_WIDTH    = 32,
  parameter int BYTE_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [1:0]               req_data_type,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_err,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [BYTE_WIDTH-1:0]    mem_wdata,
  input  logic [BYTE_WIDTH-1:0]    mem_rdata
);

  localparam int NBYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int IDX_W  = $clog2(NBYTES);

  lsu_state_t             r_state;
  logic                   r_we;
  data_type_t             r_type;
  logic [DATA_WIDTH-1:0]  r_wdata;
  logic [DATA_WIDTH-1:0]  r_acc;
  logic [IDX_W-1:0]       r_idx;
  logic [IDX_W-1:0]       r_last;

  data_type_t             w_type;
  logic                   w_err;
  logic [IDX_W-1:0]       w_idx_nxt;
  logic                   w_zero;

  assign w_type    = data_type_t'(req_data_type);
  assign w_idx_nxt = r_idx + IDX_W'(1);

`ifdef LSU_ALIGN_CHECK_EN
  assign w_err = (w_type == DT_RSVD) || misaligned(w_type, req_addr[1:0]);
`else
  assign w_err = (w_type == DT_RSVD);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      r_acc      <= '0;
      r_idx      <= '0;
      r_last     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we      <= req_we;
            r_type    <= w_type;
            r_wdata   <= req_wdata;
            r_idx     <= '0;
            r_last    <= IDX_W'(bytes_for(w_type) - 3'd1);
            req_ready <= 1'b0;
            if (w_err) begin
              r_state    <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              // First memory cycle is presented straight from the request.
              r_state   <= XFER;
              mem_we    <= req_we;
              mem_addr  <= req_addr;
              mem_wdata <= req_wdata[BYTE_WIDTH-1:0];
            end
          end
        end
        XFER: begin
          if (!r_we) r_acc[int'(r_idx)*BYTE_WIDTH +: BYTE_WIDTH] <= mem_rdata;
          if (r_idx == r_last) begin
            r_state    <= RESP;
            resp_valid <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
          end else begin
            // Address counter wraps naturally at the top of the region.
            r_idx     <= w_idx_nxt;
            mem_addr  <= mem_addr + ADDRESS_WIDTH'(1);
            mem_wdata <= r_wdata[int'(w_idx_nxt)*BYTE_WIDTH +: BYTE_WIDTH];
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_state    <= IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
            r_acc      <= '0;
          end
        end
        default: begin
          r_state   <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign w_zero = !resp_valid || r_we || resp_err;

  lsu_sext #(
    .DATA_WIDTH(DATA_WIDTH),
    .BYTE_WIDTH(BYTE_WIDTH)
  ) u_sext (
    .i_type (r_type),
    .i_acc  (r_acc),
    .i_zero (w_zero),
    .o_data (resp_rdata)
  );

endmodule

// File: doc/lsu_byte_seq.md
Name: lsu_byte_seq

Overview:
Load/store initiator that sits between the CPU datapath (ALU address, rd2 write data, writeback mux) and the byte-wide data memory. It accepts one word, halfword or byte access per request and serialises it into single-byte memory transactions, one per cycle. Read results are returned sign-extended over a valid/ready handshake.
Byte order is little-endian: the LS byte is at address A and the MS byte at A+3.

Parameters:
ADDRESS_WIDTH, 12, data-memory byte address width (0x1000-0x1FFF region offset)
DATA_WIDTH, 32, CPU-side data width
BYTE_WIDTH, 8, memory-side data width

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  synchronous, active-high reset
req_valid  in  1  CPU request present
req_ready  out  1  LSU can accept (high only in IDLE)
req_we  in  1  1=store, 0=load
req_data_type  in  2  00 word, 01 byte, 10 halfword, 11 reserved
req_addr  in  ADDRESS_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data (from rd2)
resp_valid  out  1  response present
resp_ready  in  1  CPU consumes response
resp_rdata  out  DATA_WIDTH  sign-extended load data (0 for stores/errors)
resp_err  out  1  request rejected; no memory access performed
mem_we  out  1  byte write strobe
mem_addr  out  ADDRESS_WIDTH  byte address to memory
mem_wdata  out  BYTE_WIDTH  byte to write
mem_rdata  in  BYTE_WIDTH  asynchronous read data for mem_addr in the same cycle

Behaviour:
- States are IDLE, XFER and RESP. Reset forces IDLE with all outputs 0 except req_ready=1; rdata accumulator=0.
- IDLE: req_ready=1.
  - On req_valid: latch we, type, addr and wdata; set idx=0 and last = bytes-1 (word 3, half 1, byte 0).
  - Type 11 goes directly to RESP with resp_err=1.
  - All other types go to XFER.
- XFER: mem_addr = (base + idx) mod 2^ADDRESS_WIDTH, so the address wraps at 0xFFF->0x000.
  - Store: mem_we=1 and mem_wdata = wdata byte idx.
  - Load: mem_we=0 and the accumulator byte idx <= mem_rdata at posedge.
  - idx increments each cycle. When idx==last, go to RESP.
- RESP: resp_valid=1.
  - resp_rdata is the accumulator sign-extended from bit 7 (byte), bit 15 (half) or taken as-is (word). It is 0 for stores and errors.
  - It holds stable until resp_ready. On resp_valid&&resp_ready, go to IDLE and clear the accumulator.
- Latency from accept edge to resp_valid: byte 1, half 2, word 4 cycles. Type 11 takes 1 cycle.
- There is no back-to-back accept: req_ready=0 in XFER and RESP.
- mem_we is 0 outside XFER and never asserts for loads.
- rst mid-XFER aborts immediately. Bytes already written remain in memory; no response is issued.
- req_valid while not ready is ignored, and the request must be held by the CPU.

Optional Feature:
Macro: LSU_ALIGN_CHECK_EN
- Defined: a misaligned request (half with addr[0]=1, or word with addr[1:0]!=0) goes IDLE->RESP with resp_err=1, no memory cycles, and resp_rdata=0.
- Undefined: misaligned accesses proceed byte by byte with wrap-around, and resp_err is set only for type 11.

Decomposition:
- Package lsu_pkg:
  - enum data_type_t {DT_WORD=2'b00, DT_BYTE=2'b01, DT_HALF=2'b10, DT_RSVD=2'b11}
  - enum lsu_state_t {IDLE, XFER, RESP}
  - function bytes_for(data_type_t) returning 1/2/4
- Sub-module lsu_sext: combinational sign/size extender (type + 32-bit accumulator -> resp_rdata). All sequencing stays in lsu_byte_seq.

Test Plan:
- Store word 0xDEADBEEF @0x010 -> mem writes 0x010=EF, 0x011=BE, 0x012=AD, 0x013=DE on 4 consecutive cycles; then resp_valid, resp_err=0.
- Load byte @0x010 after the above -> one mem cycle, resp_rdata=0xFFFFFFEF. Load half @0x012 -> 0xFFFFDEAD. Load word @0x010 -> 0xDEADBEEF.
- Store half 0x00001234 @0x020 with mem preset 0xFF at 0x022 -> only 0x020=34 and 0x021=12 are written, 0x022 is still 0xFF, and a half load returns 0x00001234.
- Word store @0xFFE -> writes go to 0xFFE, 0xFFF, 0x000, 0x001 when the macro is undefined. With LSU_ALIGN_CHECK_EN: resp_err=1 and mem_we never asserts.
- Type 11 request -> resp_valid next cycle with resp_err=1 and no mem_we. resp_ready held low for 5 cycles -> resp_valid and resp_rdata stable, req_ready=0 throughout.
- Assert rst during the 2nd XFER cycle of a word store -> next cycle: IDLE, req_ready=1, resp_valid=0, mem_we=0; only bytes 0 and 1 were written.
